// File: rtl/apb_default_slave_pkg.sv
// Shared types for the APB default slave: FSM state encoding and wait-counter width.
package apb_default_slave_pkg;

   localparam int WAIT_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/apb_default_slave_if.sv
// APB completer-side bus bundle; the master modport drives requests, the slave modport answers.
interface apb_default_slave_if #(
   parameter int PADDR_SIZE = 16,
   parameter int PDATA_SIZE = 32
);

   logic                  PSEL;
   logic                  PENABLE;
   logic [PADDR_SIZE-1:0] PADDR;
   logic                  PWRITE;
   logic [PDATA_SIZE-1:0] PWDATA;
   logic [PDATA_SIZE-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_default_slave_wait_cnt.sv
// Loadable down-counter that paces access-phase wait states; zero flags the last wait cycle.
module apb_wait_cnt
   import apb_default_slave_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  dec,
   input  logic [WAIT_CNT_W-1:0] load_val,
   output logic                  zero
);

   logic [WAIT_CNT_W-1:0] cnt_q;
   logic [WAIT_CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb_default_slave.sv
// Catch-all APB completer: answers every selected transfer after a fixed wait and
// records the last completed access in sticky status registers.
module apb_default_slave
   import apb_default_slave_pkg::*;
#(
   parameter int                    PADDR_SIZE  = 16,
   parameter int                    PDATA_SIZE  = 32,
   parameter int                    WAIT_STATES = 0,
   parameter int                    ERR_MODE    = 1,
   parameter logic [PDATA_SIZE-1:0] RDATA_VALUE = '0,
   parameter int                    CNT_SIZE    = 8
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   apb_default_slave_if.slave    apb,
   input  logic                  hit_clr,
   output logic                  hit_irq,
   output logic [PADDR_SIZE-1:0] hit_addr,
   output logic                  hit_write,
   output logic [CNT_SIZE-1:0]   hit_cnt
);

   state_e state_q;
   state_e state_d;

   logic wait_load;
   logic wait_dec;
   logic wait_zero;
   logic complete;

   logic                  hit_irq_q,   hit_irq_d;
   logic [PADDR_SIZE-1:0] hit_addr_q,  hit_addr_d;
   logic                  hit_write_q, hit_write_d;
   logic [CNT_SIZE-1:0]   hit_cnt_q,   hit_cnt_d;

   logic unused_pwdata;
   assign unused_pwdata = ^apb.PWDATA;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Only a genuine setup phase starts a transfer; dropping PSEL mid-transfer aborts it.
   always_comb begin
      state_d   = state_q;
      wait_load = 1'b0;
      wait_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (apb.PSEL && !apb.PENABLE) begin
               if (WAIT_STATES > 0) begin
                  state_d   = WAIT;
                  wait_load = 1'b1;
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (!apb.PSEL) begin
               state_d = IDLE;
            end else if (wait_zero) begin
               state_d = RESP;
            end else begin
               wait_dec = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      apb.PREADY  = 1'b0;
      apb.PSLVERR = 1'b0;
      apb.PRDATA  = '0;
      if (state_q == RESP) begin
         apb.PREADY  = 1'b1;
         apb.PSLVERR = (ERR_MODE != 0);
         apb.PRDATA  = RDATA_VALUE;
      end
   end

   if (WAIT_STATES > 0) begin : g_wait
      localparam logic [WAIT_CNT_W-1:0] LOAD_VAL = WAIT_CNT_W'(WAIT_STATES - 1);

      apb_wait_cnt u_wait_cnt (
         .clk      (PCLK),
         .rst      (PRESET),
         .load     (wait_load),
         .dec      (wait_dec),
         .load_val (LOAD_VAL),
         .zero     (wait_zero)
      );
   end else begin : g_no_wait
      logic unused_wait;
      assign unused_wait = wait_load ^ wait_dec;
      assign wait_zero   = 1'b1;
   end

   assign complete = (state_q == RESP) && apb.PSEL && apb.PENABLE;

   // A completion in the same cycle as a clear wins, so the new transfer is never lost.
   always_comb begin
      hit_irq_d   = hit_irq_q;
      hit_addr_d  = hit_addr_q;
      hit_write_d = hit_write_q;
      hit_cnt_d   = hit_cnt_q;
      if (complete) begin
         hit_irq_d   = 1'b1;
         hit_addr_d  = apb.PADDR;
         hit_write_d = apb.PWRITE;
         if (hit_clr) begin
            hit_cnt_d = CNT_SIZE'(1);
         end else if (hit_cnt_q != '1) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
         end
      end else if (hit_clr) begin
         hit_irq_d = 1'b0;
         hit_cnt_d = '0;
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         hit_irq_q   <= 1'b0;
         hit_addr_q  <= '0;
         hit_write_q <= 1'b0;
         hit_cnt_q   <= '0;
      end else begin
         hit_irq_q   <= hit_irq_d;
         hit_addr_q  <= hit_addr_d;
         hit_write_q <= hit_write_d;
         hit_cnt_q   <= hit_cnt_d;
      end
   end

   assign hit_irq   = hit_irq_q;
   assign hit_addr  = hit_addr_q;
   assign hit_write = hit_write_q;
   assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_apb_default_slave.sv
// Scoreboard bench for apb_default_slave: four differently configured instances share
// one bus driver; a negedge monitor checks every response against queued expectations.
module tb_apb_default_slave;

   typedef struct {
      int          id;
      logic [31:0] rdata;
      logic        slverr;
      int          cyc;
   } exp_t;

   localparam int          WS_T  [4] = '{0, 3, 0, 2};
   localparam int          ERR_T [4] = '{1, 0, 0, 1};
   localparam logic [31:0] RD_T  [4] = '{32'h0, 32'hDEADBEEF, 32'h000000A5, 32'h12345678};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        exp_q [$];

   logic [3:0]  psel = '0;
   logic        penable = 1'b0;
   logic [15:0] paddr = '0;
   logic        pwrite = 1'b0;
   logic [31:0] pwdata = '0;
   logic [3:0]  hclr = '0;

   logic        rdy   [4];
   logic        err   [4];
   logic [31:0] rdat  [4];
   logic        hirq  [4];
   logic [15:0] haddr [4];
   logic        hwr   [4];
   logic [7:0]  hcnt  [4];
   logic [1:0]  hcnt_c;

   apb_default_slave_if #(.PADDR_SIZE(16), .PDATA_SIZE(32)) bus [4] ();

   for (genvar g = 0; g < 4; g++) begin : g_bus
      assign bus[g].PSEL    = psel[g];
      assign bus[g].PENABLE = penable;
      assign bus[g].PADDR   = paddr;
      assign bus[g].PWRITE  = pwrite;
      assign bus[g].PWDATA  = pwdata;
      assign rdy[g]         = bus[g].PREADY;
      assign err[g]         = bus[g].PSLVERR;
      assign rdat[g]        = bus[g].PRDATA;
   end

   assign hcnt[2] = {6'd0, hcnt_c};

   apb_default_slave #(.WAIT_STATES(0), .ERR_MODE(1), .RDATA_VALUE(32'h0), .CNT_SIZE(8)) u_dut_a (
      .PCLK(clk), .PRESET(rst), .apb(bus[0]), .hit_clr(hclr[0]), .hit_irq(hirq[0]),
      .hit_addr(haddr[0]), .hit_write(hwr[0]), .hit_cnt(hcnt[0]));

   apb_default_slave #(.WAIT_STATES(3), .ERR_MODE(0), .RDATA_VALUE(32'hDEADBEEF), .CNT_SIZE(8)) u_dut_b (
      .PCLK(clk), .PRESET(rst), .apb(bus[1]), .hit_clr(hclr[1]), .hit_irq(hirq[1]),
      .hit_addr(haddr[1]), .hit_write(hwr[1]), .hit_cnt(hcnt[1]));

   apb_default_slave #(.WAIT_STATES(0), .ERR_MODE(0), .RDATA_VALUE(32'h000000A5), .CNT_SIZE(2)) u_dut_c (
      .PCLK(clk), .PRESET(rst), .apb(bus[2]), .hit_clr(hclr[2]), .hit_irq(hirq[2]),
      .hit_addr(haddr[2]), .hit_write(hwr[2]), .hit_cnt(hcnt_c));

   apb_default_slave #(.WAIT_STATES(2), .ERR_MODE(1), .RDATA_VALUE(32'h12345678), .CNT_SIZE(8)) u_dut_d (
      .PCLK(clk), .PRESET(rst), .apb(bus[3]), .hit_clr(hclr[3]), .hit_irq(hirq[3]),
      .hit_addr(haddr[3]), .hit_write(hwr[3]), .hit_cnt(hcnt[3]));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_status(input int id, input logic irq, input logic [7:0] cnt,
                               input logic [15:0] addr, input logic wr);
      check_output($sformatf("hit_irq[%0d]", id), 32'(hirq[id]), 32'(irq));
      check_output($sformatf("hit_cnt[%0d]", id), 32'(hcnt[id]), 32'(cnt));
      check_output($sformatf("hit_addr[%0d]", id), 32'(haddr[id]), 32'(addr));
      check_output($sformatf("hit_write[%0d]", id), 32'(hwr[id]), 32'(wr));
   endtask

   task automatic apply_stimulus(input int id, input logic [15:0] addr, input logic wr, input logic clr);
      exp_t e;
      bit   got;
      @(posedge clk); #1;
      hclr        = '0;
      psel        = '0;
      psel[id]    = 1'b1;
      penable     = 1'b0;
      paddr       = addr;
      pwrite      = wr;
      pwdata      = $urandom;
      e.id        = id;
      e.rdata     = RD_T[id];
      e.slverr    = (ERR_T[id] != 0);
      e.cyc       = cyc + WS_T[id] + 1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      penable = 1'b1;
      got     = 1'b0;
      for (int t = 0; t < 32; t++) begin
         @(negedge clk);
         if (rdy[id]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check_output("pready_timeout", 32'd0, 32'd1);
      if (clr) hclr[id] = 1'b1;
   endtask

   task automatic bus_idle();
      @(posedge clk); #1;
      psel    = '0;
      penable = 1'b0;
      hclr    = '0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            if (rdy[i]) begin
               if (exp_q.size() == 0) begin
                  check_output($sformatf("unexpected_pready[%0d]", i), 32'd1, 32'd0);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check_output("resp_dut", 32'(i), 32'(e.id));
                  check_output("resp_latency", 32'(cyc), 32'(e.cyc));
                  check_output("resp_prdata", rdat[i], e.rdata);
                  check_output("resp_pslverr", 32'(err[i]), 32'(e.slverr));
               end
            end else begin
               check_output($sformatf("idle_prdata[%0d]", i), rdat[i], 32'd0);
               check_output($sformatf("idle_pslverr[%0d]", i), 32'(err[i]), 32'd0);
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_status(0, 1'b0, 8'd0, 16'h0000, 1'b0);
      check_output("reset_pready", 32'(rdy[0]), 32'd0);

      // Single read, zero wait states, error response
      apply_stimulus(0, 16'h0010, 1'b0, 1'b0);
      bus_idle();
      check_status(0, 1'b1, 8'd1, 16'h0010, 1'b0);

      // Clear without completion keeps address and direction
      @(posedge clk); #1 hclr[0] = 1'b1;
      @(posedge clk); #1 hclr[0] = 1'b0;
      check_status(0, 1'b0, 8'd0, 16'h0010, 1'b0);

      // Four back-to-back transfers
      apply_stimulus(0, 16'h0100, 1'b1, 1'b0);
      apply_stimulus(0, 16'h0104, 1'b0, 1'b0);
      apply_stimulus(0, 16'h0108, 1'b1, 1'b0);
      apply_stimulus(0, 16'h010C, 1'b1, 1'b0);
      bus_idle();
      check_status(0, 1'b1, 8'd4, 16'h010C, 1'b1);

      // Three wait states, OKAY response with fixed read value
      apply_stimulus(1, 16'h2000, 1'b1, 1'b0);
      bus_idle();
      check_status(1, 1'b1, 8'd1, 16'h2000, 1'b1);

      // Two-bit counter saturates, then a clear coincides with completion
      for (int k = 0; k < 5; k++) apply_stimulus(2, 16'h0400 + 16'(k), 1'b0, 1'b0);
      bus_idle();
      check_status(2, 1'b1, 8'd3, 16'h0404, 1'b0);
      apply_stimulus(2, 16'h0500, 1'b1, 1'b1);
      bus_idle();
      check_status(2, 1'b1, 8'd1, 16'h0500, 1'b1);

      // Abort in the first wait cycle, then a normal transfer
      @(posedge clk); #1;
      psel[3] = 1'b1; penable = 1'b0; paddr = 16'h3000; pwrite = 1'b1;
      @(posedge clk); #1;
      psel = '0;
      repeat (4) @(posedge clk);
      #1 check_status(3, 1'b0, 8'd0, 16'h0000, 1'b0);
      apply_stimulus(3, 16'h3004, 1'b1, 1'b0);
      bus_idle();
      check_status(3, 1'b1, 8'd1, 16'h3004, 1'b1);

      // Reset pulse during a wait cycle
      @(posedge clk); #1;
      psel[3] = 1'b1; penable = 1'b0; paddr = 16'h3008; pwrite = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; psel = '0; penable = 1'b0;
      check_output("rst_pready", 32'(rdy[3]), 32'd0);
      check_output("rst_pslverr", 32'(err[3]), 32'd0);
      check_output("rst_prdata", rdat[3], 32'd0);
      check_status(3, 1'b0, 8'd0, 16'h0000, 1'b0);

      repeat (6) @(posedge clk);
      #1 check_output("pending_responses", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
